// File: rtl/rs_pkg.sv
// rs_pkg -- shared GF(16) definitions for the RS(15,11), t=2 decoder back end.
//   Field: GF(2^4), primitive polynomial x^4+x+1, alpha = 2.
//   Provides: element type, code constants, the Chien term multipliers,
//   the decoder FSM state type, and the general GF multiply/inverse.
// No ports (package).
package rs_pkg;

    localparam int GF_W = 4;
    localparam logic [GF_W:0] PRIM_POLY = 5'b10011;   // x^4 + x + 1
    localparam int N = 15;
    localparam int K = 11;

    typedef logic [GF_W-1:0] gf_t;

    localparam gf_t ALPHA  = 4'h2;
    localparam gf_t ALPHA2 = 4'h4;

    // Chien term registers: 0 = G1*X, 1 = G2*X^2, 2 = O1*X.
    // Each step moves X from alpha^-j to alpha^-(j-1), i.e. multiplies X by alpha.
    localparam int  N_TERMS = 3;
    localparam gf_t TERM_COEF [N_TERMS] = '{ALPHA, ALPHA2, ALPHA};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // General GF(16) multiply: shift-and-add with reduction by PRIM_POLY.
    function automatic gf_t gf_mul(input gf_t a, input gf_t b);
        gf_t acc;
        gf_t sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < GF_W; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = sh[GF_W-1] ? ({sh[GF_W-2:0], 1'b0} ^ PRIM_POLY[GF_W-1:0])
                            : {sh[GF_W-2:0], 1'b0};
        end
        return acc;
    endfunction

    // Inverse as a^14 = a^2 * a^4 * a^8; yields 0 for a = 0.
    function automatic gf_t gf_inv(input gf_t a);
        gf_t a2;
        gf_t a4;
        gf_t a8;
        a2 = gf_mul(a, a);
        a4 = gf_mul(a2, a2);
        a8 = gf_mul(a4, a4);
        return gf_mul(gf_mul(a2, a4), a8);
    endfunction

endpackage

// File: rtl/chien_forney_if.sv
// chien_forney_if -- handshake and data bundle for the Chien search / Forney block.
//   in_valid/in_ready           : word handshake (accepted when both high)
//   Omega_0..1, Gamma_0..2      : normalized evaluator / locator coefficients
//   sym_valid, sym_idx, err_sym : one beat per codeword position, 14 down to 0
//   done, err_cnt, dec_fail     : end-of-word status, valid with the idx 0 beat
// Modports: slave = the decoder block, master = the producer/consumer side.
interface chien_forney_if;
    import rs_pkg::*;

    logic in_valid;
    logic in_ready;
    gf_t  Omega_0;
    gf_t  Omega_1;
    gf_t  Gamma_0;
    gf_t  Gamma_1;
    gf_t  Gamma_2;
    logic sym_valid;
    logic [3:0] sym_idx;
    gf_t  err_sym;
    logic done;
    logic [1:0] err_cnt;
    logic dec_fail;

    modport slave (
        input  in_valid, Omega_0, Omega_1, Gamma_0, Gamma_1, Gamma_2,
        output in_ready, sym_valid, sym_idx, err_sym, done, err_cnt, dec_fail
    );

    modport master (
        output in_valid, Omega_0, Omega_1, Gamma_0, Gamma_1, Gamma_2,
        input  in_ready, sym_valid, sym_idx, err_sym, done, err_cnt, dec_fail
    );

endinterface

// File: rtl/gf_const_mul.sv
// gf_const_mul -- multiply a GF(16) element by a fixed coefficient.
//   Parameter COEF : constant multiplier (folds to an XOR network).
//   a (in 4)       : operand
//   y (out 4)      : a * COEF
module gf_const_mul
    import rs_pkg::*;
#(
    parameter gf_t COEF = ALPHA
) (
    input  gf_t a,
    output gf_t y
);

    assign y = gf_mul(a, COEF);

endmodule

// File: rtl/chien_forney.sv
// chien_forney -- Chien search plus Forney magnitude for RS(15,11), t=2, b=1.
//   CLK (in 1) : rising-edge clock
//   RST (in 1) : synchronous active-high reset
//   cf         : chien_forney_if.slave (handshake, coefficients, symbol stream, status)
// A word is accepted in IDLE, scanned over 15 cycles (positions 14..0), and
// each position emerges two edges after it is evaluated. done/err_cnt/dec_fail
// accompany the idx 0 beat. Throughput is one word per 17 cycles.
// Optional feature: define DEC_FAIL_CHECK_EN to build the degree/consistency
// check driving dec_fail; otherwise dec_fail is tied low.
module chien_forney
    import rs_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    chien_forney_if.slave   cf
);

    localparam logic [3:0] IDX_FIRST = 4'(N - 1);

    state_t state_reg, state_next;

    logic       accept;
    logic       scan;

    logic [3:0] idx_reg;
    gf_t        g0_reg;
    gf_t        o0_reg;
    gf_t        ginv_reg;

    gf_t        term_reg [N_TERMS];
    gf_t        term_in  [N_TERMS];
    gf_t        term_src [N_TERMS];
    gf_t        term_mul [N_TERMS];

    gf_t        lambda;
    gf_t        mag;
    logic       hit;

    // evaluation stage
    logic       a_valid_reg;
    logic [3:0] a_idx_reg;
    logic       a_hit_reg;
    gf_t        a_sym_reg;

    // output stage
    logic       sym_valid_reg;
    logic [3:0] sym_idx_reg;
    gf_t        err_sym_reg;
    logic       done_reg;
    logic [1:0] cnt_reg;
    logic [1:0] cnt_next;

    assign accept = (state_reg == IDLE) && cf.in_valid;
    assign scan   = (state_reg == SCAN);

    // ---------------- FSM ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cf.in_valid) state_next = SCAN;
            SCAN:    if (idx_reg == '0) state_next = FLUSH;
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- term multipliers ----------------
    // In IDLE the multipliers see the incoming coefficients, so the load value
    // is already X = alpha^-14 = alpha^1; during SCAN they advance the registers.
    assign term_in[0] = cf.Gamma_1;
    assign term_in[1] = cf.Gamma_2;
    assign term_in[2] = cf.Omega_1;

    generate
        for (genvar gi = 0; gi < N_TERMS; gi++) begin : g_term
            assign term_src[gi] = (state_reg == IDLE) ? term_in[gi] : term_reg[gi];

            gf_const_mul #(
                .COEF (TERM_COEF[gi])
            ) u_mul (
                .a (term_src[gi]),
                .y (term_mul[gi])
            );
        end
    endgenerate

    // Lambda(X) = G0 + G1 X + G2 X^2 ; e = (O0 + O1 X) * inv(G1)
    assign lambda = g0_reg ^ term_reg[0] ^ term_reg[1];
    assign hit    = (lambda == '0);
    assign mag    = gf_mul(o0_reg ^ term_reg[2], ginv_reg);

    always_comb begin
        cnt_next = cnt_reg;
        if (a_hit_reg && (cnt_reg != 2'd3)) begin
            cnt_next = cnt_reg + 2'd1;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_reg       <= '0;
            g0_reg        <= '0;
            o0_reg        <= '0;
            ginv_reg      <= '0;
            for (int i = 0; i < N_TERMS; i++) begin
                term_reg[i] <= '0;
            end
            a_valid_reg   <= 1'b0;
            a_idx_reg     <= '0;
            a_hit_reg     <= 1'b0;
            a_sym_reg     <= '0;
            sym_valid_reg <= 1'b0;
            sym_idx_reg   <= '0;
            err_sym_reg   <= '0;
            done_reg      <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            if (accept) begin
                idx_reg  <= IDX_FIRST;
                g0_reg   <= cf.Gamma_0;
                o0_reg   <= cf.Omega_0;
                ginv_reg <= gf_inv(cf.Gamma_1);
            end else if (scan && (idx_reg != '0)) begin
                idx_reg  <= idx_reg - 4'd1;
            end

            if (accept || scan) begin
                for (int i = 0; i < N_TERMS; i++) begin
                    term_reg[i] <= term_mul[i];
                end
            end

            a_valid_reg   <= scan;
            a_idx_reg     <= scan ? idx_reg : '0;
            a_hit_reg     <= scan && hit;
            a_sym_reg     <= (scan && hit) ? mag : '0;

            sym_valid_reg <= a_valid_reg;
            sym_idx_reg   <= a_idx_reg;
            err_sym_reg   <= a_sym_reg;
            done_reg      <= a_valid_reg && (a_idx_reg == '0);

            if (accept) begin
                cnt_reg <= '0;
            end else if (a_valid_reg) begin
                cnt_reg <= cnt_next;
            end
        end
    end

    // ---------------- decode-failure check ----------------
`ifdef DEC_FAIL_CHECK_EN
    logic [1:0] deg_reg;
    logic       fail_static_reg;
    logic       dec_fail_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            deg_reg         <= '0;
            fail_static_reg <= 1'b0;
            dec_fail_reg    <= 1'b0;
        end else begin
            if (accept) begin
                deg_reg <= (cf.Gamma_2 != '0) ? 2'd2 :
                           (cf.Gamma_1 != '0) ? 2'd1 : 2'd0;
                // G1 = 0 with G2 != 0 has a repeated root: not correctable.
                fail_static_reg <= (cf.Gamma_0 != 4'h1) ||
                                   ((cf.Gamma_1 == '0) && (cf.Gamma_2 != '0));
            end
            dec_fail_reg <= a_valid_reg && (a_idx_reg == '0) &&
                            (fail_static_reg || (cnt_next != deg_reg));
        end
    end

    assign cf.dec_fail = dec_fail_reg;
`else
    assign cf.dec_fail = 1'b0;
`endif

    assign cf.in_ready  = (state_reg == IDLE);
    assign cf.sym_valid = sym_valid_reg;
    assign cf.sym_idx   = sym_idx_reg;
    assign cf.err_sym   = err_sym_reg;
    assign cf.done      = done_reg;
    assign cf.err_cnt   = cnt_reg;

endmodule

// File: doc/chien_forney.md
CHIEN_FORNEY -- requirements
Module: chien_forney

Interface
REQ-001 SHALL have ports: CLK in 1, rising-edge clock; RST in 1, synchronous active-high reset.
REQ-002 SHALL have ports: in_valid in 1, high when the normalized polynomials are valid; in_ready out 1, high when the block can accept a word.
REQ-003 SHALL have ports: Omega_0, Omega_1 in 4 each, normalized evaluator coefficients; Gamma_0, Gamma_1, Gamma_2 in 4 each, normalized locator coefficients.
REQ-004 SHALL have ports: sym_valid out 1; sym_idx out 4, codeword position 14..0; err_sym out 4, error magnitude (0 means no error).
REQ-005 SHALL have ports: done out 1, one-cycle pulse; err_cnt out 2, roots found; dec_fail out 1, uncorrectable word.

Function
REQ-006 SHALL work over GF(16) with p(x)=x^4+x+1, alpha=2, RS(15,11), t=2, first consecutive root b=1.
REQ-007 SHALL define Lambda(x)=G0+G1x+G2x^2; position j is in error iff Lambda(alpha^-j)=0; magnitude e_j = (O0+O1*alpha^-j)*inv(G1); inv(0) SHALL be 0.
REQ-008 SHALL implement FSM states IDLE, SCAN and FLUSH; in_ready SHALL be 1 only in IDLE.
REQ-009 SHALL handle the handshake as follows: on in_valid&in_ready at edge T, load the term registers G1*alpha, G2*alpha^2 and O1*alpha, register O0, G0 and inv(G1), then enter SCAN.
REQ-010 SHALL stay in SCAN for 15 cycles (T+1..T+15), evaluating one position per cycle in order j=14 down to 0, then multiply the term registers by alpha, alpha^2 and alpha respectively.
REQ-011 SHALL register the outputs: position j appears at edge T+16-j with sym_valid=1 and sym_idx=j; err_sym SHALL be e_j on a hit and 0 otherwise.
REQ-012 SHALL assert done together with sym_idx=0 (edge T+16), with err_cnt including position 0; FLUSH SHALL be at T+16 and IDLE SHALL be at T+17; throughput SHALL be 17 cycles per word.
REQ-013 SHALL compute deg = 2 if G2!=0, 1 if G2=0 and G1!=0, otherwise 0.
REQ-014 SHALL assert dec_fail with done if err_cnt!=deg, G0!=1, or G1=0 with G2!=0; in the last case magnitudes SHALL be 0.
REQ-015 SHALL saturate err_cnt at 3.
REQ-016 SHALL provide no output backpressure; the consumer takes every sym_valid beat and discards the word when dec_fail=1.
REQ-017 SHALL ignore in_valid outside IDLE; sym_valid and done SHALL be 0 outside the scan output window.

Reset
REQ-018 SHALL, when RST=1 at an edge, force IDLE, in_ready=1 and all other outputs and registers to 0.
REQ-019 SHALL, on reset mid-SCAN, abandon the word: no done pulse and no further sym_valid beats.

Configuration
REQ-020 SHALL, with DEC_FAIL_CHECK_EN defined, implement REQ-013/014; without it, dec_fail SHALL be tied 0 and the deg logic removed, with all other behaviour identical.

Structure
REQ-021 SHALL place GF constants in a shared package rs_pkg: primitive polynomial, N=15, K=11, alpha and alpha^2 multiplier constants, and the GF element width of 4.
REQ-022 SHALL use one sub-module, gf_const_mul (constant-coefficient GF multiply), for the term updates; the existing general GF multiplier and inverse SHALL be reused for inv(G1) and the magnitude.

Verification
REQ-023 No errors: G=(1,0,0), O=(0,0) -> 15 beats with err_sym=0, err_cnt=0, dec_fail=0.
REQ-024 Single error: G=(1,8,0), O=(5,0) -> idx3 err_sym=6, all other beats 0, err_cnt=1, dec_fail=0.
REQ-025 Double error: G=(1,3,2), O=(3,0) -> idx1 and idx0 err_sym=1, err_cnt=2, dec_fail=0.
REQ-026 Failure: G=(1,0,1), O=(1,0) -> err_cnt=1, all magnitudes 0, dec_fail=1 with the macro defined and 0 without it.
REQ-027 Reset at T+8 -> sym_valid=0 from the next edge, no done, in_ready=1; a new word accepted afterwards matches REQ-024.
REQ-028 Back-to-back: in_valid held high -> second acceptance at T+17; in_valid during SCAN is ignored.
